pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage ARM core. Keeps a shadow copy of the destination/control of the instructions in EXE and MEM, and compares it against the source registers decoded in ID. Drives the ID stage's `hazard` input, the IF/ID and ID/EXE `flush` inputs, and a global freeze for memory wait states. Also keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose : bundle of ID/EXE/MEM control inputs and hazard/flush/freeze outputs of the hazard controller.
// Latency : n/a (wiring only).
// Backpress: n/a; freeze carries the memory wait state back to the pipeline.
//
// Signals:
//   id_src1/id_src2/id_two_src/id_ignore_hazard : source operands decoded in ID
//   id_wb_en/id_mem_r_en/id_dest                : control of the ID instruction (captured into the EXE slot)
//   exe_branch_taken                            : branch resolved taken in EXE
//   mem_ready                                   : data memory completes this cycle (0 = wait state)
//   cnt_clr                                     : synchronous clear of the performance counters
//   hazard/flush/freeze                         : pipeline sequencing outputs
//   stall_cnt/flush_cnt                         : saturating performance counters
// Modports: master = pipeline side (drives ID/EXE/MEM info), slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             id_ignore_hazard;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic [3:0]       id_dest;
    logic             exe_branch_taken;
    logic             mem_ready;
    logic             cnt_clr;
    logic             hazard;
    logic             flush;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_src1, id_src2, id_two_src, id_ignore_hazard,
        output id_wb_en, id_mem_r_en, id_dest,
        output exe_branch_taken, mem_ready, cnt_clr,
        input  hazard, flush, freeze, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, id_ignore_hazard,
        input  id_wb_en, id_mem_r_en, id_dest,
        input  exe_branch_taken, mem_ready, cnt_clr,
        output hazard, flush, freeze, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : RAW-hazard / branch-flush / memory-freeze sequencing for the 5-stage core, with stall/flush counters.
// Latency : hazard, flush and freeze are combinational (zero cycles); shadow slots and counters update per edge.
// Backpress: mem_ready=0 raises freeze, which holds both shadow slots and both counters.
//
// Ports: clk (rising edge), rst (async, active-high), bus (pipeline_hazard_ctrl_if.slave).
// Optional feature: define PIPE_FORWARDING_EN when the core has an EXE forwarding unit;
// then only load-use against the EXE slot stalls and the MEM slot is not kept.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r_en;
        logic [3:0] dest;
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            ex_s_q, ex_s_d;
    logic             raw;
    logic             hazard, flush, freeze;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic match(input slot_t s, input logic [3:0] src1,
                                   input logic [3:0] src2, input logic two_src);
        return s.valid & s.wb_en & ((src1 == s.dest) | (two_src & (src2 == s.dest)));
    endfunction

`ifdef PIPE_FORWARDING_EN
    // Forwarding covers every ALU result; only a load in EXE has no data yet.
    always_comb begin
        raw = !bus.id_ignore_hazard
              & match(ex_s_q, bus.id_src1, bus.id_src2, bus.id_two_src)
              & ex_s_q.mem_r_en;
    end
`else
    slot_t mem_s_q;
    logic  unused_mem_r_en;

    // WB writes the register file before ID reads it, so EXE and MEM are the only producers to check.
    always_comb begin
        raw = !bus.id_ignore_hazard
              & (match(ex_s_q,  bus.id_src1, bus.id_src2, bus.id_two_src)
               | match(mem_s_q, bus.id_src1, bus.id_src2, bus.id_two_src));
    end

    assign unused_mem_r_en = mem_s_q.mem_r_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_s_q <= '0;
        end else if (!freeze) begin
            mem_s_q <= ex_s_q;
        end
    end
`endif

    // Fixed priority freeze > flush > hazard. A branch seen during a wait
    // state is simply held in EXE, so the flush happens once memory is ready.
    always_comb begin
        freeze = !bus.mem_ready;
        flush  = bus.exe_branch_taken & bus.mem_ready;
        hazard = raw & bus.mem_ready & !bus.exe_branch_taken;
    end

    // EXE slot next state: bubble on flush or stall, otherwise capture ID.
    always_comb begin
        ex_s_d = ex_s_q;
        if (!freeze) begin
            if (flush || hazard) begin
                ex_s_d = '0;
            end else begin
                ex_s_d = '{valid: 1'b1, wb_en: bus.id_wb_en,
                           mem_r_en: bus.id_mem_r_en, dest: bus.id_dest};
            end
        end
    end

    // Saturating counters; clear wins over increment, freeze holds everything.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!freeze) begin
            if (bus.cnt_clr) begin
                stall_cnt_d = '0;
                flush_cnt_d = '0;
            end else begin
                if (hazard && (stall_cnt_q != CNT_MAX)) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                if (flush && (flush_cnt_q != CNT_MAX)) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_s_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_s_q      <= ex_s_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.hazard    = hazard;
    assign bus.flush     = flush;
    assign bus.freeze    = freeze;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
    localparam int W = 4;
`ifdef PIPE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(W)) bus ();
    pipeline_hazard_ctrl #(.CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic set_id(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                          input logic ign, input logic wb, input logic mr, input logic [3:0] d);
        bus.id_src1          = s1;
        bus.id_src2          = s2;
        bus.id_two_src       = two;
        bus.id_ignore_hazard = ign;
        bus.id_wb_en         = wb;
        bus.id_mem_r_en      = mr;
        bus.id_dest          = d;
    endtask

    task automatic idle();
        set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        idle();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.exe_branch_taken = 1'b0;
        bus.cnt_clr = 1'b0;
        idle();
        #2;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL rst_hazard: got %b want 0", bus.hazard); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", bus.flush); end
        n_cmp++; if (bus.freeze !== 1'b0) begin n_err++; $display("FAIL rst_freeze: got %b want 0", bus.freeze); end
        n_cmp++; if (bus.stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", bus.stall_cnt); end
        n_cmp++; if (bus.flush_cnt !== 4'd0) begin n_err++; $display("FAIL rst_flush_cnt: got %0d want 0", bus.flush_cnt); end
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.freeze !== 1'b1) begin n_err++; $display("FAIL rst_freeze_follow: got %b want 1", bus.freeze); end
        bus.mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.hazard !== 1'b0 || bus.flush !== 1'b0 || bus.freeze !== 1'b0)
            begin n_err++; $display("FAIL post_rst_outs: got h%b f%b z%b want 000", bus.hazard, bus.flush, bus.freeze); end
        n_cmp++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0)
            begin n_err++; $display("FAIL post_rst_cnts: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
    endtask

    // ADD R1 followed by SUB reading R1.
    task automatic test_raw_exe();
        clear_all();
        set_id(4'd3, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL raw_exe_c0: got %b want 0", bus.hazard); end
        tick();
        set_id(4'd1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6);
        #1;
        n_cmp++; if (bus.hazard !== !FWD) begin n_err++; $display("FAIL raw_exe_c1: got %b want %b", bus.hazard, !FWD); end
        tick();
        n_cmp++; if (bus.hazard !== !FWD) begin n_err++; $display("FAIL raw_exe_c2: got %b want %b", bus.hazard, !FWD); end
        tick();
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL raw_exe_c3: got %b want 0", bus.hazard); end
        idle();
        tick();
        n_cmp++; if (bus.stall_cnt !== (FWD ? 4'd0 : 4'd2))
            begin n_err++; $display("FAIL raw_exe_cnt: got %0d want %0d", bus.stall_cnt, FWD ? 0 : 2); end
    endtask

    // LDR R2 followed by ADD with src2=R2.
    task automatic test_load_use();
        clear_all();
        set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
        tick();
        set_id(4'd7, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        #1;
        n_cmp++; if (bus.hazard !== 1'b1) begin n_err++; $display("FAIL load_use_c1: got %b want 1", bus.hazard); end
        tick();
        n_cmp++; if (bus.hazard !== !FWD) begin n_err++; $display("FAIL load_use_c2: got %b want %b", bus.hazard, !FWD); end
        tick();
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL load_use_c3: got %b want 0", bus.hazard); end
        idle();
        tick();
        n_cmp++; if (bus.stall_cnt !== (FWD ? 4'd1 : 4'd2))
            begin n_err++; $display("FAIL load_use_cnt: got %0d want %0d", bus.stall_cnt, FWD ? 1 : 2); end
    endtask

    // Producer of R15 two instructions ahead: MEM-only dependence.
    task automatic test_mem_only_pc();
        clear_all();
        set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15);
        tick();
        idle();
        tick();
        set_id(4'd15, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
        #1;
        n_cmp++; if (bus.hazard !== !FWD) begin n_err++; $display("FAIL mem_pc_c1: got %b want %b", bus.hazard, !FWD); end
        tick();
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL mem_pc_c2: got %b want 0", bus.hazard); end
        idle();
        tick();
        n_cmp++; if (bus.stall_cnt !== (FWD ? 4'd0 : 4'd1))
            begin n_err++; $display("FAIL mem_pc_cnt: got %0d want %0d", bus.stall_cnt, FWD ? 0 : 1); end
    endtask

    task automatic test_no_dep();
        clear_all();
        set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        tick();
        set_id(4'd1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL ignore_hazard: got %b want 0", bus.hazard); end
        set_id(4'd5, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL src2_not_real: got %b want 0", bus.hazard); end
        set_id(4'd5, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        #1;
        n_cmp++; if (bus.hazard !== !FWD) begin n_err++; $display("FAIL src2_real: got %b want %b", bus.hazard, !FWD); end
        idle();
        tick();
        tick();
    endtask

    // Branch taken while ID has a load-use dependence on EXE.
    task automatic test_branch_raw();
        clear_all();
        set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        tick();
        set_id(4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
        bus.exe_branch_taken = 1'b1;
        #1;
        n_cmp++; if (bus.flush !== 1'b1 || bus.hazard !== 1'b0)
            begin n_err++; $display("FAIL branch_raw_outs: got flush %b hazard %b want 1 0", bus.flush, bus.hazard); end
        tick();
        bus.exe_branch_taken = 1'b0;
        n_cmp++; if (bus.flush_cnt !== 4'd1) begin n_err++; $display("FAIL branch_flush_cnt: got %0d want 1", bus.flush_cnt); end
        n_cmp++; if (bus.stall_cnt !== 4'd0) begin n_err++; $display("FAIL branch_stall_cnt: got %0d want 0", bus.stall_cnt); end
        // Reads the squashed instruction's dest; only a bubble in EXE gives no hazard.
        set_id(4'd7, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
        #1;
        n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL branch_bubble: got %b want 0", bus.hazard); end
        idle();
        tick();
        tick();
    endtask

    task automatic test_freeze_branch();
        clear_all();
        set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
        tick();
        set_id(4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
        bus.exe_branch_taken = 1'b1;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.freeze !== 1'b1 || bus.flush !== 1'b0 || bus.hazard !== 1'b0)
                begin n_err++; $display("FAIL freeze_c%0d: got z%b f%b h%b want 1 0 0", i, bus.freeze, bus.flush, bus.hazard); end
            tick();
        end
        n_cmp++; if (bus.flush_cnt !== 4'd0) begin n_err++; $display("FAIL freeze_flush_cnt: got %0d want 0", bus.flush_cnt); end
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++; if (bus.freeze !== 1'b0 || bus.flush !== 1'b1 || bus.hazard !== 1'b0)
            begin n_err++; $display("FAIL freeze_release: got z%b f%b h%b want 0 1 0", bus.freeze, bus.flush, bus.hazard); end
        tick();
        bus.exe_branch_taken = 1'b0;
        n_cmp++; if (bus.flush_cnt !== 4'd1) begin n_err++; $display("FAIL deferred_flush_cnt: got %0d want 1", bus.flush_cnt); end
        // The load R9 was held in EXE through the freeze and is now in MEM.
        #1;
        n_cmp++; if (bus.hazard !== !FWD) begin n_err++; $display("FAIL freeze_slots_held: got %b want %b", bus.hazard, !FWD); end
        idle();
        tick();
        tick();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        int stalls;
        clear_all();
        exp_cnt = 0;
        stalls  = FWD ? 1 : 2;
        for (int p = 0; p < 17; p++) begin
            set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
            tick();
            set_id(4'd6, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
            for (int s = 0; s < stalls; s++) begin
                #1;
                n_cmp++; if (bus.hazard !== 1'b1) begin n_err++; $display("FAIL sat_hazard p%0d s%0d: got %b want 1", p, s, bus.hazard); end
                tick();
                if (exp_cnt < 15) exp_cnt++;
            end
            n_cmp++; if (bus.stall_cnt !== exp_cnt[3:0])
                begin n_err++; $display("FAIL sat_cnt p%0d: got %0d want %0d", p, bus.stall_cnt, exp_cnt); end
            tick();
        end
        n_cmp++; if (bus.stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_final: got %0d want 15", bus.stall_cnt); end
        idle();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        n_cmp++; if (bus.stall_cnt !== 4'd0) begin n_err++; $display("FAIL sat_clr: got %0d want 0", bus.stall_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        set_id(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
        tick();
        set_id(4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        tick();
        n_cmp++; if (bus.stall_cnt !== 4'd1 || bus.hazard !== !FWD)
            begin n_err++; $display("FAIL mid_pre: got cnt %0d hazard %b want 1 %b", bus.stall_cnt, bus.hazard, !FWD); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.hazard !== 1'b0 || bus.stall_cnt !== 4'd0)
            begin n_err++; $display("FAIL mid_rst: got hazard %b cnt %0d want 0 0", bus.hazard, bus.stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_raw_exe();
        test_load_use();
        test_mem_only_pc();
        test_no_dep();
        test_branch_raw();
        test_freeze_branch();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
